lc2k_multicycle_control: RTL and testbench

Multicycle control FSM for the LC2K core, replacing single-cycle opcode decode.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Waits on a variable-latency memory handshake, with a parametrised timeout.
- Drives all datapath mux selects and write strobes, and counts retired instructions.
- Sits between the instruction register/ALU flags and the datapath muxes, register file and memory port.

---
 rtl/lc2k_multicycle_control_if.sv | 40 ++++
 rtl/lc2k_multicycle_control.sv | 202 ++++++++++++++++++++
 tb/tb_lc2k_multicycle_control.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc2k_multicycle_control_if.sv
// Control/status bundle between the LC2K multicycle controller and the datapath.
interface lc2k_multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic [2:0]       opcode;
  logic             alu_eq;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             ir_write;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             reg_write;
  logic             reg_dst;
  logic [1:0]       wb_sel;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic             halted;
  logic             mem_error;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       state;

  // Controller side
  modport master (
    input  start, opcode, alu_eq, mem_ready,
    output pc_write, pc_sel, ir_write, mem_req, mem_we, mem_addr_sel,
           reg_write, reg_dst, wb_sel, alu_src_b, alu_op, halted, mem_error,
           instr_count, state
  );

  // Datapath / memory side
  modport slave (
    output start, opcode, alu_eq, mem_ready,
    input  pc_write, pc_sel, ir_write, mem_req, mem_we, mem_addr_sel,
           reg_write, reg_dst, wb_sel, alu_src_b, alu_op, halted, mem_error,
           instr_count, state
  );
endinterface

// File: rtl/lc2k_multicycle_control.sv
// LC2K multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives
// datapath selects and strobes, times out stalled memory, counts retirements.
module lc2k_multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  lc2k_multicycle_control_if.master bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // Last wait count at which a still-missing mem_ready becomes a timeout
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  logic [2:0]        state_q, state_nxt;
  logic [2:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  cnt_q;

  logic       pc_write_c, ir_write_c, mem_req_c, mem_we_c, mem_addr_sel_c;
  logic       reg_write_c, reg_dst_c, alu_src_b_c, halted_c, mem_error_c;
  logic [1:0] pc_sel_c, wb_sel_c, alu_op_c;
  logic       retire_c;
  logic       wait_expired_c;

  assign wait_expired_c = TIMEOUT_EN && (wait_cnt_q == WAIT_LAST);

  // Next-state and datapath control decode
  always_comb begin
    state_nxt      = state_q;
    pc_write_c     = 1'b0;
    pc_sel_c       = 2'd0;
    ir_write_c     = 1'b0;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    reg_write_c    = 1'b0;
    reg_dst_c      = 1'b0;
    wb_sel_c       = 2'd0;
    alu_src_b_c    = 1'b0;
    alu_op_c       = 2'd0;
    halted_c       = 1'b0;
    mem_error_c    = 1'b0;
    retire_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          state_nxt  = S_DECODE;
        end else if (wait_expired_c) begin
          state_nxt = S_ERROR;
        end
      end
      S_DECODE: begin
        // Decode looks at the live opcode; later states use the latched copy
        case (bus.opcode)
          OP_HALT: begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_nxt  = S_HALT;
          end
          OP_NOOP: begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_nxt  = S_FETCH;
          end
          default: state_nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD, OP_NOR: begin
            alu_src_b_c = 1'b1;
            alu_op_c    = (op_q == OP_NOR) ? 2'd1 : 2'd0;
            state_nxt   = S_WB;
          end
          OP_LW, OP_SW: begin
            state_nxt = S_MEM;
          end
          OP_BEQ: begin
            alu_src_b_c = 1'b1;
            alu_op_c    = 2'd2;
            pc_write_c  = 1'b1;
            pc_sel_c    = bus.alu_eq ? 2'd1 : 2'd0;
            retire_c    = 1'b1;
            state_nxt   = S_FETCH;
          end
          OP_JALR: begin
            // regA is captured by the datapath before this write lands
            reg_write_c = 1'b1;
            wb_sel_c    = 2'd2;
            pc_write_c  = 1'b1;
            pc_sel_c    = 2'd2;
            retire_c    = 1'b1;
            state_nxt   = S_FETCH;
          end
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        mem_we_c       = (op_q == OP_SW);
        if (bus.mem_ready) begin
          if (op_q == OP_SW) begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_nxt  = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_expired_c) begin
          state_nxt = S_ERROR;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        retire_c    = 1'b1;
        state_nxt   = S_FETCH;
        if (op_q != OP_LW) begin
          reg_dst_c = 1'b1;
          wb_sel_c  = 2'd1;
        end
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      S_ERROR: begin
        mem_error_c = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nxt;
  end

  // Opcode latch, captured once per instruction in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_q <= 3'd0;
    else if (state_q == S_DECODE) op_q <= bus.opcode;
  end

  // Memory wait counter: clears on every state change, counts stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wait_cnt_q <= '0;
    else if (state_nxt != state_q)       wait_cnt_q <= '0;
    else if (mem_req_c && !bus.mem_ready) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
  end

  // Saturating retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt_q <= '0;
    else if (retire_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.pc_write     = pc_write_c;
  assign bus.pc_sel       = pc_sel_c;
  assign bus.ir_write     = ir_write_c;
  assign bus.mem_req      = mem_req_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_addr_sel = mem_addr_sel_c;
  assign bus.reg_write    = reg_write_c;
  assign bus.reg_dst      = reg_dst_c;
  assign bus.wb_sel       = wb_sel_c;
  assign bus.alu_src_b    = alu_src_b_c;
  assign bus.alu_op       = alu_op_c;
  assign bus.halted       = halted_c;
  assign bus.mem_error    = mem_error_c;
  assign bus.instr_count  = cnt_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_lc2k_multicycle_control.sv
// Bench for lc2k_multicycle_control: directed vectors, randomized instruction
// stream against an instruction-level model, and timeout/halt/reset sequences.
module tb_lc2k_multicycle_control;

  localparam logic [2:0] OP_ADD = 3'd0, OP_NOR = 3'd1, OP_LW = 3'd2, OP_SW = 3'd3;
  localparam logic [2:0] OP_BEQ = 3'd4, OP_JALR = 3'd5, OP_HALT = 3'd6, OP_NOOP = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [2:0] late;   // opcode shown on the IR after DECODE
    logic       eq;
    int         fs;     // fetch stall cycles
    int         ms;     // mem stall cycles
    int         cyc;    // cycles from first FETCH to retire
    int         regw;   // reg_write cycles
    int         mcyc;   // cycles with mem_req and mem_addr_sel
    int         we;     // cycles with mem_req and mem_we
    logic [1:0] sel;    // pc_sel on the pc_write cycle
    logic [2:0] wdst;   // {reg_dst, wb_sel} on the reg_write cycle
    logic [2:0] alu;    // OR of {alu_src_b, alu_op} over the instruction
  } vec_t;

  logic       clk, rst_n, start, alu_eq, mem_ready;
  logic [2:0] opcode;
  int         tests = 0;
  int         fails = 0;
  int         model_cnt = 0;

  lc2k_multicycle_control_if #(.CNT_W(32)) bus ();
  lc2k_multicycle_control_if #(.CNT_W(3))  bus2 ();

  assign bus.start      = start;
  assign bus.opcode     = opcode;
  assign bus.alu_eq     = alu_eq;
  assign bus.mem_ready  = mem_ready;
  assign bus2.start     = start;
  assign bus2.opcode    = opcode;
  assign bus2.alu_eq    = alu_eq;
  assign bus2.mem_ready = mem_ready;

  lc2k_multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Narrow counter, timeout disabled; runs in lockstep with u_dut
  lc2k_multicycle_control #(.MEM_TIMEOUT(0), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.pc_write, bus.pc_sel, bus.ir_write, bus.mem_req, bus.mem_we,
            bus.mem_addr_sel, bus.reg_write, bus.reg_dst, bus.wb_sel,
            bus.alu_src_b, bus.alu_op, bus.halted, bus.mem_error};
  endfunction

  function automatic logic [15:0] exp_o(logic pcw, logic [1:0] pcs, logic irw, logic mreq,
                                        logic mwe, logic masel, logic rw, logic rdst,
                                        logic [1:0] wbs, logic asrc, logic [1:0] aop,
                                        logic hlt, logic merr);
    return {pcw, pcs, irw, mreq, mwe, masel, rw, rdst, wbs, asrc, aop, hlt, merr};
  endfunction

  // Instruction-level reference: latency and side effects from the ISA rules
  function automatic vec_t model(logic [2:0] op, logic eq, int fs, int ms);
    vec_t e;
    e = '{op, 3'd0, eq, fs, ms, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0};
    case (op)
      OP_ADD, OP_NOR: begin
        e.cyc = 4 + fs; e.regw = 1; e.wdst = 3'b101;
        e.alu = (op == OP_NOR) ? 3'b101 : 3'b100;
      end
      OP_LW:   begin e.cyc = 5 + fs + ms; e.regw = 1; e.mcyc = ms + 1; end
      OP_SW:   begin e.cyc = 4 + fs + ms; e.mcyc = ms + 1; e.we = ms + 1; end
      OP_BEQ:  begin e.cyc = 3 + fs; e.sel = eq ? 2'd1 : 2'd0; e.alu = 3'b110; end
      OP_JALR: begin e.cyc = 3 + fs; e.regw = 1; e.sel = 2'd2; e.wdst = 3'b010; end
      default: e.cyc = 2 + fs;
    endcase
    return e;
  endfunction

  task automatic drive(input logic st, input logic [2:0] op, input logic eq, input logic rdy);
    @(negedge clk);
    start = st; opcode = op; alu_eq = eq; mem_ready = rdy;
    #1;
  endtask

  // Runs one instruction from its first FETCH cycle until its pc_write cycle
  task automatic run_instr(input vec_t v, output vec_t m, output bit done, output int irw);
    int fw, mw, phase;
    fw = 0; mw = 0; phase = 0; irw = 0; done = 0;
    m = '{v.op, v.late, v.eq, v.fs, v.ms, 0, 0, 0, 0, 2'd0, 3'd0, 3'd0};
    while (!done && m.cyc < 60) begin
      @(negedge clk);
      start  = 1'b0;
      alu_eq = v.eq;
      opcode = (phase == 1) ? v.op : (phase == 2) ? v.late : 3'($urandom);
      if (bus.mem_req) begin
        if (phase == 0) begin mem_ready = (fw == v.fs); fw++; end
        else            begin mem_ready = (mw == v.ms); mw++; end
      end else begin
        mem_ready = 1'($urandom);
      end
      #1;
      m.cyc++;
      if (bus.ir_write) irw++;
      if (phase == 2 && bus.mem_req && bus.mem_addr_sel) m.mcyc++;
      if (bus.mem_req && bus.mem_we) m.we++;
      if (bus.reg_write) begin m.regw++; m.wdst = {bus.reg_dst, bus.wb_sel}; end
      m.alu = m.alu | {bus.alu_src_b, bus.alu_op};
      if (bus.pc_write) begin done = 1; m.sel = bus.pc_sel; end
      if (phase == 1) phase = 2;
      else if (phase == 0 && bus.mem_req && mem_ready) phase = 1;
    end
  endtask

  task automatic check_meas(input vec_t e, input vec_t m, input bit done, input int irw);
    check("retire_within_bound", 64'(done), 64'd1);
    check($sformatf("cycles op%0d", e.op), 64'(m.cyc), 64'(e.cyc));
    check($sformatf("reg_write op%0d", e.op), 64'(m.regw), 64'(e.regw));
    check($sformatf("mem_cycles op%0d", e.op), 64'(m.mcyc), 64'(e.mcyc));
    check($sformatf("mem_we op%0d", e.op), 64'(m.we), 64'(e.we));
    check($sformatf("pc_sel op%0d", e.op), 64'(m.sel), 64'(e.sel));
    check($sformatf("wb_dst op%0d", e.op), 64'(m.wdst), 64'(e.wdst));
    check($sformatf("alu_ctl op%0d", e.op), 64'(m.alu), 64'(e.alu));
    check("ir_write_once", 64'(irw), 64'd1);
  endtask

  task automatic finish_instr(input logic [2:0] exp_state);
    @(posedge clk);
    #1;
    model_cnt++;
    check("instr_count", 64'(bus.instr_count), 64'(model_cnt));
    check("instr_count_sat", 64'(bus2.instr_count), 64'((model_cnt > 7) ? 7 : model_cnt));
    check("state_after_retire", 64'(bus.state), 64'(exp_state));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0;
    #1;
    check("reset_outs", 64'(outs()), 64'd0);
    check("reset_state", 64'(bus.state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic do_start();
    drive(1'b1, 3'($urandom), 1'b0, 1'b0);
    check("idle_on_start", 64'(bus.state), 64'd0);
  endtask

  vec_t       vecs[10];
  vec_t       m, e;
  bit         done;
  int         irw, k;

  initial begin
    vecs[0] = '{OP_ADD,  OP_NOOP, 1'b0,  0,  0,  4, 1,  0,  0, 2'd0, 3'b101, 3'b100};
    vecs[1] = '{OP_NOR,  OP_BEQ,  1'b0,  2,  0,  6, 1,  0,  0, 2'd0, 3'b101, 3'b101};
    vecs[2] = '{OP_LW,   OP_SW,   1'b0,  0,  3,  8, 1,  4,  0, 2'd0, 3'b000, 3'b000};
    vecs[3] = '{OP_SW,   OP_ADD,  1'b0,  1,  2,  7, 0,  3,  3, 2'd0, 3'b000, 3'b000};
    vecs[4] = '{OP_BEQ,  OP_ADD,  1'b1,  0,  0,  3, 0,  0,  0, 2'd1, 3'b000, 3'b110};
    vecs[5] = '{OP_BEQ,  OP_JALR, 1'b0,  0,  0,  3, 0,  0,  0, 2'd0, 3'b000, 3'b110};
    vecs[6] = '{OP_JALR, OP_LW,   1'b1,  0,  0,  3, 1,  0,  0, 2'd2, 3'b010, 3'b000};
    vecs[7] = '{OP_NOOP, OP_ADD,  1'b0,  1,  0,  3, 0,  0,  0, 2'd0, 3'b000, 3'b000};
    vecs[8] = '{OP_SW,   OP_LW,   1'b0, 14, 14, 32, 0, 15, 15, 2'd0, 3'b000, 3'b000};
    vecs[9] = '{OP_ADD,  OP_NOR,  1'b0, 14,  0, 18, 1,  0,  0, 2'd0, 3'b101, 3'b100};

    rst_n = 1'b1; start = 1'b0; opcode = 3'd0; alu_eq = 1'b0; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("por_outs", 64'(outs()), 64'd0);
    check("por_state", 64'(bus.state), 64'd0);
    check("por_count", 64'(bus.instr_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // add: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH
    do_start();
    drive(1'b0, 3'd5, 1'b0, 1'b1);
    check("add_fetch_state", 64'(bus.state), 64'd1);
    check("add_fetch_outs", 64'(outs()), 64'(exp_o(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    drive(1'b0, OP_ADD, 1'b0, 1'b1);
    check("add_decode_state", 64'(bus.state), 64'd2);
    check("add_decode_outs", 64'(outs()), 64'd0);
    drive(1'b0, OP_ADD, 1'b0, 1'b1);
    check("add_exec_state", 64'(bus.state), 64'd3);
    check("add_exec_outs", 64'(outs()), 64'(exp_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)));
    drive(1'b0, OP_ADD, 1'b0, 1'b1);
    check("add_wb_state", 64'(bus.state), 64'd5);
    check("add_wb_outs", 64'(outs()), 64'(exp_o(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0)));
    finish_instr(3'd1);

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i], m, done, irw);
      check_meas(vecs[i], m, done, irw);
      finish_instr(3'd1);
    end

    // Randomized instruction stream
    for (int i = 0; i < 100; i++) begin
      k = $urandom_range(0, 6);
      e = model((k == 6) ? OP_NOOP : 3'(k), 1'($urandom),
                ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3));
      e.late = 3'($urandom);
      run_instr(e, m, done, irw);
      check_meas(e, m, done, irw);
      finish_instr(3'd1);
    end

    // Async reset while lw is stalled in MEM
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    drive(1'b0, OP_LW, 1'b0, 1'b1);
    drive(1'b0, OP_ADD, 1'b0, 1'b1);
    check("lw_exec_state", 64'(bus.state), 64'd3);
    drive(1'b0, OP_ADD, 1'b0, 1'b0);
    check("lw_mem_outs", 64'(outs()), 64'(exp_o(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0)));
    #1 rst_n = 1'b0;
    #1;
    check("midlw_reset_outs", 64'(outs()), 64'd0);
    check("midlw_reset_state", 64'(bus.state), 64'd0);
    check("midlw_reset_count", 64'(bus.instr_count), 64'd0);
    check("midlw_reset_count_sat", 64'(bus2.instr_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;

    // Timeout: ready on the 15th FETCH cycle wins, 15 misses go to ERROR
    do_start();
    for (int i = 0; i < 14; i++) drive(1'b0, 3'($urandom), 1'b0, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    check("fetch_ready_at_limit", 64'({bus.state, bus.ir_write, bus.mem_error}), 64'({3'd1, 1'b1, 1'b0}));
    drive(1'b0, OP_NOOP, 1'b0, 1'b1);
    check("decode_after_late_ready", 64'({bus.state, bus.pc_write}), 64'({3'd2, 1'b1}));
    finish_instr(3'd1);
    for (int i = 0; i < 15; i++) drive(1'b0, 3'($urandom), 1'b0, 1'b0);
    check("fetch_wait_15", 64'({bus.state, bus.mem_error}), 64'({3'd1, 1'b0}));
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    check("timeout_state", 64'(bus.state), 64'd7);
    check("timeout_outs", 64'(outs()), 64'(exp_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    for (int i = 0; i < 3; i++) drive(1'b1, OP_ADD, 1'b0, 1'b1);
    check("error_terminal", 64'({bus.state, bus.instr_count}), 64'({3'd7, 32'd1}));
    for (int i = 0; i < 30; i++) drive(1'b0, 3'd0, 1'b0, 1'b0);
    check("no_timeout_when_disabled", 64'({bus2.state, bus2.mem_error}), 64'({3'd1, 1'b0}));

    // halt after three noops; start is ignored in HALT
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      e = model((i == 3) ? OP_HALT : OP_NOOP, 1'b0, i, 0);
      e.late = 3'($urandom);
      run_instr(e, m, done, irw);
      check_meas(e, m, done, irw);
      finish_instr((i == 3) ? 3'd6 : 3'd1);
    end
    check("halt_outs", 64'(outs()), 64'(exp_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
    for (int i = 0; i < 3; i++) drive(1'b1, 3'($urandom), 1'b0, 1'b1);
    drive(1'b0, 3'd0, 1'b0, 1'b1);
    check("halt_terminal", 64'({bus.state, bus.halted, bus.instr_count}), 64'({3'd6, 1'b1, 32'd4}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
